// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Declarations shared by the FP32 datapath blocks (integer-to-float converter
// and FP32 adder): IEEE-754 single-precision field widths and bias, field
// slice/pack helpers, and the converter's FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package fp32_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } cvt_state_t;

    function automatic logic fp_sign(input logic [31:0] w);
        return w[31];
    endfunction

    function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] w);
        return w[30:23];
    endfunction

    function automatic logic [FP_MAN_W-1:0] fp_man(input logic [31:0] w);
        return w[22:0];
    endfunction

    function automatic logic [31:0] fp_pack(input logic                s,
                                            input logic [FP_EXP_W-1:0] e,
                                            input logic [FP_MAN_W-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/int_to_fp32_converter_if.sv
// -----------------------------------------------------------------------------
// int_to_fp32_converter_if
// Valid/ready bus of the integer-to-FP32 converter.
//   in_valid/in_ready/in_data            : integer operand, upstream -> converter
//   out_valid/out_ready/out_data/out_inexact : FP32 result, converter -> downstream
// Modports: slave = converter side, master = side that feeds and drains it.
// -----------------------------------------------------------------------------
interface int_to_fp32_converter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic            out_inexact;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/fp32_round_rne.sv
// -----------------------------------------------------------------------------
// fp32_round_rne
// Combinational round-to-nearest-even of a normalised FP32 significand.
//   i_exp/i_man       : biased exponent and 23-bit fraction before rounding
//   i_guard/i_sticky  : first dropped bit and OR of all lower dropped bits
//   o_exp/o_man       : rounded exponent and fraction
//   o_inexact         : any non-zero bit was dropped
// -----------------------------------------------------------------------------
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [FP_EXP_W-1:0] i_exp,
    input  logic [FP_MAN_W-1:0] i_man,
    input  logic                i_guard,
    input  logic                i_sticky,
    output logic [FP_EXP_W-1:0] o_exp,
    output logic [FP_MAN_W-1:0] o_man,
    output logic                o_inexact
);
    logic                w_round_up;
    logic [FP_MAN_W:0]   w_man_inc;

    // A tie (guard set, sticky clear) rounds up only from an odd fraction.
    assign w_round_up = i_guard & (i_sticky | i_man[0]);
    assign w_man_inc  = {1'b0, i_man} + {{FP_MAN_W{1'b0}}, w_round_up};

    // Carry out of an all-ones fraction leaves the fraction at zero and
    // moves the hidden one up into the exponent.
    assign o_man     = w_man_inc[FP_MAN_W-1:0];
    assign o_exp     = i_exp + {{(FP_EXP_W-1){1'b0}}, w_man_inc[FP_MAN_W]};
    assign o_inexact = i_guard | i_sticky;
endmodule

// File: rtl/int_to_fp32_converter.sv
// -----------------------------------------------------------------------------
// int_to_fp32_converter
// Converts an XLEN-bit integer (two's complement when SIGNED=1, unsigned
// otherwise) to an IEEE-754 single-precision word. The magnitude is
// normalised one left shift per cycle, then rounded to nearest-even.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of int_to_fp32_converter_if
//          (in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_inexact)
// Latency from the accepting edge: leading-zeros(mag)+2 cycles, zero is
// short-circuited straight to the result state.
// -----------------------------------------------------------------------------
module int_to_fp32_converter
    import fp32_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit SIGNED = 1'b1
)(
    input  logic                         clk,
    input  logic                         rst,
    int_to_fp32_converter_if.slave       bus
);
    // Exponent of a value whose leading one sits in bit XLEN-1.
    localparam logic [FP_EXP_W-1:0] EXP_INIT = FP_EXP_W'(FP_BIAS + XLEN - 1);

    cvt_state_t          r_state;
    cvt_state_t          w_state_nxt;

    logic                r_sign;
    logic [XLEN-1:0]     r_mag;
    logic [FP_EXP_W-1:0] r_exp;
    logic [31:0]         r_out_data;
    logic                r_out_inexact;

    logic                w_in_sign;
    logic [XLEN-1:0]     w_in_mag;
    logic                w_in_zero;

    logic [FP_MAN_W-1:0] w_man;
    logic                w_guard;
    logic                w_sticky;
    logic [FP_EXP_W-1:0] w_rnd_exp;
    logic [FP_MAN_W-1:0] w_rnd_man;
    logic                w_rnd_inexact;

    // Negation wraps, so the most negative input gives mag = 2^(XLEN-1).
    assign w_in_sign = SIGNED && bus.in_data[XLEN-1];
    assign w_in_mag  = w_in_sign ? -bus.in_data : bus.in_data;
    assign w_in_zero = (w_in_mag == '0);

    // Once normalised the leading one is implicit; the 23 bits below it are
    // the fraction, the next bit is guard and everything else is sticky.
    assign w_man    = r_mag[XLEN-2 -: FP_MAN_W];
    assign w_guard  = r_mag[XLEN-25];
    assign w_sticky = |r_mag[XLEN-26:0];

    fp32_round_rne u_round (
        .i_exp     (r_exp),
        .i_man     (w_man),
        .i_guard   (w_guard),
        .i_sticky  (w_sticky),
        .o_exp     (w_rnd_exp),
        .o_man     (w_rnd_man),
        .o_inexact (w_rnd_inexact)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = w_in_zero ? DONE : NORM;
            NORM:    if (r_mag[XLEN-1]) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign        <= 1'b0;
            r_mag         <= '0;
            r_exp         <= '0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= w_in_sign;
                        r_mag  <= w_in_mag;
                        r_exp  <= EXP_INIT;
                        // Zero skips normalise/round, so publish it here.
                        if (w_in_zero) begin
                            r_out_data    <= '0;
                            r_out_inexact <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!r_mag[XLEN-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - FP_EXP_W'(1);
                    end
                end
                ROUND: begin
                    r_out_data    <= fp_pack(r_sign, w_rnd_exp, w_rnd_man);
                    r_out_inexact <= w_rnd_inexact;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_inexact = r_out_inexact;
endmodule

// File: tb/tb_int_to_fp32_converter.sv
// -----------------------------------------------------------------------------
// tb_int_to_fp32_converter
// Bench for int_to_fp32_converter: one signed and one unsigned instance,
// a directed vector table, random conversions against an arithmetic model,
// and hand-written backpressure and mid-conversion reset sequences.
// -----------------------------------------------------------------------------
module tb_int_to_fp32_converter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    int_to_fp32_converter_if #(.XLEN(32)) bus_s ();
    int_to_fp32_converter_if #(.XLEN(32)) bus_u ();

    int_to_fp32_converter #(.XLEN(32), .SIGNED(1'b1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int_to_fp32_converter #(.XLEN(32), .SIGNED(1'b0)) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bus_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          u;
        logic [31:0] din;
        logic [31:0] dout;
        logic        inex;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: locate the leading one, keep 24 significant bits, and
    // round the discarded remainder against exactly half an ulp.
    function automatic void model(input bit u, input logic [31:0] d,
                                  output logic [31:0] r, output logic inex, output int lat);
        longint unsigned mag, kept, rem, half;
        bit s;
        int p, e, sh;
        s   = !u && d[31];
        mag = s ? ((64'd1 << 32) - longint'(d)) : longint'(d);
        r = 32'h0; inex = 1'b0; lat = 1;
        if (mag == 0) return;
        p = 0;
        for (int i = 0; i < 32; i++) if (((mag >> i) & 64'd1) != 0) p = i;
        e   = 127 + p;
        rem = 0;
        if (p <= 23) begin
            kept = mag << (23 - p);
        end else begin
            sh   = p - 23;
            kept = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && (kept & 64'd1) != 0)) kept = kept + 1;
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                e    = e + 1;
            end
        end
        r    = {s, 8'(e), 23'(kept)};
        inex = (rem != 0);
        lat  = (31 - p) + 2;
    endfunction

    function automatic logic f_ovalid(input bit u);
        return u ? bus_u.out_valid : bus_s.out_valid;
    endfunction

    function automatic logic f_iready(input bit u);
        return u ? bus_u.in_ready : bus_s.in_ready;
    endfunction

    function automatic logic [31:0] f_odata(input bit u);
        return u ? bus_u.out_data : bus_s.out_data;
    endfunction

    function automatic logic f_oinex(input bit u);
        return u ? bus_u.out_inexact : bus_s.out_inexact;
    endfunction

    task automatic set_in(input bit u, input logic v, input logic [31:0] d);
        if (u) begin
            bus_u.in_valid = v; bus_u.in_data = d;
        end else begin
            bus_s.in_valid = v; bus_s.in_data = d;
        end
    endtask

    task automatic set_ordy(input bit u, input logic v);
        if (u) bus_u.out_ready = v;
        else   bus_s.out_ready = v;
    endtask

    // Called #1 after a rising edge. Waits until out_valid is seen with
    // out_ready low; lat counts edges after the accepting edge.
    task automatic wait_result(input bit u, output int lat);
        lat = 0;
        while (!f_ovalid(u) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!f_ovalid(u)) check("result_timeout", 0, 1);
    endtask

    task automatic accept(input bit u, input logic [31:0] d);
        int n;
        n = 0;
        while (!f_iready(u) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!f_iready(u)) check("ready_timeout", 0, 1);
        set_in(u, 1'b1, d);
        @(posedge clk); #1;
        set_in(u, 1'b0, 32'h0);
    endtask

    task automatic release_result(input bit u);
        set_ordy(u, 1'b1);
        @(posedge clk); #1;
        set_ordy(u, 1'b0);
        check("drain_valid", f_ovalid(u), 0);
        check("drain_ready", f_iready(u), 1);
    endtask

    task automatic run_conv(input bit u, input logic [31:0] d,
                            output logic [31:0] r, output logic inex, output int lat);
        accept(u, d);
        wait_result(u, lat);
        r    = f_odata(u);
        inex = f_oinex(u);
        release_result(u);
    endtask

    initial begin
        vec_t        vecs[9];
        logic [31:0] r, er, cap;
        logic        inex, einex;
        int          lat, elat, seen;
        bit          u;
        logic [31:0] d;

        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 32'h00000003, 32'h40400000, 1'b0, 32};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 33};
        vecs[2] = '{1'b0, 32'h00000000, 32'h00000000, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h80000000, 32'hCF000000, 1'b0, 2};
        vecs[4] = '{1'b0, 32'h7FFFFFFF, 32'h4F000000, 1'b1, 3};
        vecs[5] = '{1'b0, 32'h01000001, 32'h4B800000, 1'b1, 9};
        vecs[6] = '{1'b0, 32'h01000003, 32'h4B800002, 1'b1, 9};
        vecs[7] = '{1'b1, 32'hFFFFFFFF, 32'h4F800000, 1'b1, 2};
        vecs[8] = '{1'b0, 32'h00000005, 32'h40A00000, 1'b0, 31};

        rst = 1'b1;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.out_ready = 1'b0;
        bus_u.in_valid = 1'b0; bus_u.in_data = '0; bus_u.out_ready = 1'b0;
        #2;
        check("rst_in_ready",  bus_s.in_ready, 1);
        check("rst_out_valid", bus_s.out_valid, 0);
        check("rst_out_data",  bus_s.out_data, 0);
        check("rst_inexact",   bus_s.out_inexact, 0);
        check("rst_u_in_ready", bus_u.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].u, vecs[i].din, r, inex, lat);
            check($sformatf("vec%0d_data", i), r, vecs[i].dout);
            check($sformatf("vec%0d_inexact", i), inex, vecs[i].inex);
            if (vecs[i].din == 32'h0) check($sformatf("vec%0d_zero_lat", i), (lat <= vecs[i].lat), 1);
            else                      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Backpressure: result and in_ready held while downstream stalls,
        // and a new in_valid presented meanwhile is ignored.
        model(1'b0, 32'h00012345, er, einex, elat);
        accept(1'b0, 32'h00012345);
        set_in(1'b0, 1'b1, 32'h0BAD0000);
        wait_result(1'b0, lat);
        cap = bus_s.out_data;
        check("bp_data", cap, er);
        check("bp_inexact", bus_s.out_inexact, einex);
        check("bp_lat", lat, elat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_hold_data", bus_s.out_data, cap);
            check("bp_hold_valid", bus_s.out_valid, 1);
            check("bp_hold_ready", bus_s.in_ready, 0);
        end
        bus_s.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_s.out_ready = 1'b0;
        check("bp_release_valid", bus_s.out_valid, 0);
        check("bp_release_ready", bus_s.in_ready, 1);
        set_in(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("bp_no_accept_valid", bus_s.out_valid, 0);
        check("bp_no_accept_ready", bus_s.in_ready, 1);

        // Asynchronous reset in the middle of normalisation.
        accept(1'b0, 32'h00000001);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  bus_s.in_ready, 1);
        check("mid_rst_out_valid", bus_s.out_valid, 0);
        check("mid_rst_out_data",  bus_s.out_data, 0);
        check("mid_rst_inexact",   bus_s.out_inexact, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus_s.out_valid) seen++;
        end
        check("mid_rst_no_valid", seen, 0);
        run_conv(1'b0, 32'h00000005, r, inex, lat);
        check("after_rst_data", r, 32'h40A00000);
        check("after_rst_inexact", inex, 0);

        // Random conversions on both instances.
        for (int n = 0; n < 200; n++) begin
            u = 1'($urandom_range(0, 1));
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) d = -d;
            model(u, d, er, einex, elat);
            run_conv(u, d, r, inex, lat);
            check($sformatf("rnd_data u=%0d d=%h", u, d), r, er);
            check($sformatf("rnd_inexact u=%0d d=%h", u, d), inex, einex);
            if (d == 32'h0) check("rnd_zero_lat", (lat <= 1), 1);
            else            check($sformatf("rnd_lat u=%0d d=%h", u, d), lat, elat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_to_fp32_converter.md
Name: int_to_fp32_converter

Overview:
- Converts an XLEN-bit integer (two's complement or unsigned) into an IEEE-754 single-precision word.
- Sits upstream of the FP32 adder and supplies its A/B operands from integer sources. It is the integer-to-float counterpart of the adder's float consumption.
- Multi-cycle: iterative leading-zero normalisation (one shift per cycle), then a round-to-nearest-even stage.
- Valid/ready handshake on both sides.

Parameters:
- XLEN, 32, integer input width; legal range 26..64.
- SIGNED, 1, 1 = input is two's complement, 0 = input is unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept an input
- in_data  input  XLEN  integer operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  32  FP32 result {sign, exp[7:0], man[22:0]}
- out_inexact  output  1  result was rounded (guard | sticky non-zero)

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset: state=IDLE; in_ready=1; out_valid=0; out_data=0; out_inexact=0. An operation in flight when reset asserts is discarded and no partial result appears.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: sign = SIGNED & in_data[XLEN-1]; mag = sign ? -in_data : in_data, as XLEN-bit unsigned, so the most negative value yields mag = 2^(XLEN-1); exp = 127+XLEN-1.
  - If mag==0, go to DONE with out_data=0x00000000 and inexact=0. Otherwise go to NORM.
- NORM:
  - If mag[XLEN-1]==1, go to ROUND.
  - Otherwise mag<<=1 and exp-=1, then stay in NORM. Exactly one shift per cycle.
- ROUND (combinational stage, registered into out_data):
  - man = mag[XLEN-2:XLEN-24]; G = mag[XLEN-25]; S = OR of mag[XLEN-26:0].
  - Round up iff G & (S | man[0]).
  - If man is all ones and rounds up: man=0, exp+=1.
  - out_inexact = G|S. Go to DONE.
- DONE:
  - out_valid=1. out_data and out_inexact are held stable while out_ready=0. in_ready=0.
  - On out_ready: go to IDLE and deassert out_valid on the next edge. No new input is accepted in that same cycle.
- Latency, measured from the accepting edge to the first cycle with out_valid=1:
  - lz+2 cycles for non-zero inputs, where lz = leading zeros of mag.
  - 1 cycle for zero.
  - For XLEN=32, worst case is 33 cycles (mag=1).
- in_ready is 0 in every state except IDLE. in_valid while busy is ignored; the upstream must hold it.
- Exponent is never out of range for XLEN ≤ 64, so no overflow/inf/denormal path exists.
- Registers are cleared only by rst. There is no synchronous clear.

Decomposition:
- Shared package fp32_pkg:
  - FP_EXP_W=8, FP_MAN_W=23, FP_BIAS=127.
  - Field-slice helpers for sign/exp/man.
  - The converter state enum (IDLE/NORM/ROUND/DONE).
  - Shared with the adder.
- One sub-module: fp32_round_rne.
  - Combinational.
  - Inputs: 8-bit exp, 23-bit man, guard, sticky.
  - Outputs: rounded exp/man and inexact.
  - Reused later by the adder's rounding path.

Test Plan:
- in_data=3 (XLEN=32, SIGNED=1) -> out_data=0x40400000, inexact=0, out_valid 32 cycles after accept.
- in_data=0xFFFFFFFF (-1) -> 0xBF800000, inexact=0; in_data=0 -> 0x00000000, out_valid 1 cycle after accept.
- in_data=0x80000000 (-2^31) -> 0xCF000000, inexact=0, latency 2; in_data=0x7FFFFFFF -> 0x4F000000, inexact=1 (mantissa overflow bumps the exponent).
- Ties: 0x01000001 -> 0x4B800000 (round to even, down), inexact=1; 0x01000003 -> 0x4B800002 (round to even, up), inexact=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises.
  - out_data must stay stable and in_ready=0 throughout.
  - Assert out_ready: out_valid drops next edge and in_ready returns to 1.
  - SIGNED=0 with 0xFFFFFFFF -> 0x4F800000, inexact=1.
- Reset mid-NORM:
  - Accept in_data=1, assert rst asynchronously at cycle 5.
  - Outputs must go to reset values immediately, and no out_valid may follow.
  - The next conversion (in_data=5) yields 0x40A00000.
